// File: rtl/vliw_slot_scheduler.sv
// vliw_slot_scheduler: issues the three slots of a VLIW bundle (A, B, C) onto
// shared execution units. A slot can issue in any cycle once its unit is free.
// Slots compete for units in fixed priority A > B > C. The bundle retires when
// its last pending slot issues.
module vliw_slot_scheduler #(
  parameter int unsigned DIV_LATENCY = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        bundle_valid,
  output logic        bundle_ready,
  input  logic [2:0]  slot_en,
  input  logic [2:0]  op_a,
  input  logic [2:0]  op_b,
  input  logic [2:0]  op_c,
  input  logic        mem_ready,
  output logic [2:0]  issue_valid,
  output logic        bundle_done,
  output logic        sched_stall,
  output logic        div_busy,
  output logic [31:0] stall_cycle_count
);

  localparam int NUM_SLOTS = 3;

  typedef enum logic [2:0] {
    OP_ALU    = 3'b000,
    OP_MUL    = 3'b001,
    OP_DIV    = 3'b010,
    OP_FPU    = 3'b011,
    OP_MEMORY = 3'b100,
    OP_BRANCH = 3'b101,
    OP_SYSTEM = 3'b110,
    OP_NOP    = 3'b111
  } op_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  // The divider counter is 4 bits wide. DIV_LATENCY is limited to 1..15 so it
  // fits in the counter.
  localparam logic [3:0] DIV_LOAD = 4'(DIV_LATENCY);

  state_t                          state;
  logic [NUM_SLOTS-1:0]            pending;
  logic [NUM_SLOTS-1:0][2:0]       ops_q;
  logic [3:0]                      div_cnt;

  logic [NUM_SLOTS-1:0]            grant;
  logic [NUM_SLOTS-1:0]            remaining;
  logic [7:0]                      unit_used;
  logic                            div_grant;
  logic [NUM_SLOTS-1:0]            live_mask;

  assign div_busy     = (div_cnt != 4'd0);
  assign bundle_ready = (state == IDLE) && !flush;
  assign issue_valid  = grant;
  assign remaining    = pending & ~grant;
  assign bundle_done  = (state == ISSUE) && !flush && (remaining == '0);
  assign sched_stall  = (state == ISSUE) && !flush && (remaining != '0);

  // NOP slots never need a unit, so they are dropped from pending at accept.
  assign live_mask = {op_t'(op_c) != OP_NOP, op_t'(op_b) != OP_NOP,
                      op_t'(op_a) != OP_NOP};

  // Walk the pending slots in priority order. A non-ALU unit is claimed by the
  // first slot that wins it. ALU has no claim and can issue on all three slots.
  always_comb begin
    grant     = '0;
    unit_used = '0;
    div_grant = 1'b0;
    if (state == ISSUE && !flush) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (pending[i]) begin
          case (op_t'(ops_q[i]))
            OP_ALU: grant[i] = 1'b1;
            OP_NOP: ;
            OP_DIV: begin
              if (!unit_used[ops_q[i]] && !div_busy) begin
                grant[i]              = 1'b1;
                unit_used[ops_q[i]]   = 1'b1;
                div_grant             = 1'b1;
              end
            end
            OP_MEMORY: begin
              if (!unit_used[ops_q[i]] && mem_ready) begin
                grant[i]            = 1'b1;
                unit_used[ops_q[i]] = 1'b1;
              end
            end
            default: begin
              if (!unit_used[ops_q[i]]) begin
                grant[i]            = 1'b1;
                unit_used[ops_q[i]] = 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  // Bundle FSM: accept in IDLE, retire pending slots in ISSUE, flush discards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      ops_q   <= {NUM_SLOTS{OP_NOP}};
    end else if (flush) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bundle_valid) begin
            ops_q   <= {op_c, op_b, op_a};
            pending <= slot_en & live_mask;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          pending <= remaining;
          if (remaining == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Divider occupancy. A flush does not stop a divide that is already running.
  always_ff @(posedge clk) begin
    if (rst)                  div_cnt <= 4'd0;
    else if (div_grant)       div_cnt <= DIV_LOAD;
    else if (div_cnt != 4'd0) div_cnt <= div_cnt - 4'd1;
  end

  // Saturating count of the cycles in which the bundle needed another cycle.
  always_ff @(posedge clk) begin
    if (rst)                                            stall_cycle_count <= '0;
    else if (sched_stall && stall_cycle_count != '1)    stall_cycle_count <= stall_cycle_count + 32'd1;
  end

endmodule

// File: tb/tb_vliw_slot_scheduler.sv
// Directed bench for vliw_slot_scheduler. The expected values in each scenario
// are worked out by hand in the surrounding comments.
module tb_vliw_slot_scheduler;

  localparam logic [2:0] ALU = 3'b000, MUL = 3'b001, DIV = 3'b010, FPU = 3'b011,
                         MEM = 3'b100, BRA = 3'b101, SYS = 3'b110, NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst, flush, bundle_valid, mem_ready;
  logic [2:0]  slot_en, op_a, op_b, op_c;
  logic        bundle_ready, bundle_done, sched_stall, div_busy;
  logic [2:0]  issue_valid;
  logic [31:0] stall_cycle_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_cnt;

  vliw_slot_scheduler #(.DIV_LATENCY(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bundle_valid(bundle_valid),
    .bundle_ready(bundle_ready), .slot_en(slot_en), .op_a(op_a), .op_b(op_b),
    .op_c(op_c), .mem_ready(mem_ready), .issue_valid(issue_valid),
    .bundle_done(bundle_done), .sched_stall(sched_stall), .div_busy(div_busy),
    .stall_cycle_count(stall_cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Step one clock. Inputs change 2 time units after the edge, and checks are
  // made 1 unit later, so neither happens near the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic offer(input logic [2:0] en, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] c);
    bundle_valid = 1'b1;
    slot_en = en; op_a = a; op_b = b; op_c = c;
  endtask

  task automatic outs(input string tag, input logic [2:0] iv, input logic dn, input logic st);
    settle();
    chk({tag, ".issue"}, 32'(issue_valid), 32'(iv));
    chk({tag, ".done"},  32'(bundle_done), 32'(dn));
    chk({tag, ".stall"}, 32'(sched_stall), 32'(st));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; bundle_valid = 1'b0; mem_ready = 1'b1;
    slot_en = 3'b000; op_a = NOP; op_b = NOP; op_c = NOP;
    tick(); tick();
    rst = 1'b0;
    // State right after reset.
    settle();
    chk("rst.ready", 32'(bundle_ready), 32'd1);
    chk("rst.divbusy", 32'(div_busy), 32'd0);
    chk("rst.count", stall_cycle_count, 32'd0);
    outs("rst", 3'b000, 1'b0, 1'b0);
    exp_cnt = 0;

    // ALU/ALU/ALU: accepted, and all three issue in the next cycle.
    offer(3'b111, ALU, ALU, ALU);
    outs("alu.accept", 3'b000, 1'b0, 1'b0);
    tick(); bundle_valid = 1'b0;
    outs("alu.issue", 3'b111, 1'b1, 1'b0);
    chk("alu.notready", 32'(bundle_ready), 32'd0);
    tick();
    settle();
    chk("alu.idle_ready", 32'(bundle_ready), 32'd1);

    // MUL/MUL/ALU: A and C issue (101), then B issues and the bundle is done.
    offer(3'b111, MUL, MUL, ALU);
    tick(); bundle_valid = 1'b0;
    outs("mul.c1", 3'b101, 1'b0, 1'b1);
    tick();
    outs("mul.c2", 3'b010, 1'b1, 1'b0);
    exp_cnt += 1;
    chk("mul.count", stall_cycle_count, exp_cnt);
    tick();

    // DIV/NOP/NOP issues at T. DIV/ALU/NOP is offered and accepted at T+1.
    // ALU issues at T+2. The divider is busy from T+1 to T+8, so the DIV
    // issues at T+9. That gives stall cycles T+2..T+8, which is 7.
    offer(3'b111, DIV, NOP, NOP);
    tick();
    offer(3'b111, DIV, ALU, NOP);
    outs("div.T", 3'b001, 1'b1, 1'b0);
    chk("div.T.ready", 32'(bundle_ready), 32'd0);
    tick();
    settle();
    chk("div.T1.ready", 32'(bundle_ready), 32'd1);
    chk("div.T1.busy", 32'(div_busy), 32'd1);
    tick(); bundle_valid = 1'b0;
    outs("div.T2", 3'b010, 1'b0, 1'b1);
    for (int k = 3; k <= 8; k++) begin
      tick();
      outs($sformatf("div.T%0d", k), 3'b000, 1'b0, 1'b1);
    end
    chk("div.T8.busy", 32'(div_busy), 32'd1);
    tick();
    outs("div.T9", 3'b001, 1'b1, 1'b0);
    chk("div.T9.busy", 32'(div_busy), 32'd0);
    exp_cnt += 7;
    chk("div.count", stall_cycle_count, exp_cnt);

    // Assert rst 3 cycles after the DIV grant at T+9. The divide and the
    // count are abandoned.
    tick(); tick(); tick();
    settle();
    chk("rstdiv.busy_before", 32'(div_busy), 32'd1);
    rst = 1'b1;
    offer(3'b001, ALU, NOP, NOP);
    tick(); rst = 1'b0; bundle_valid = 1'b0;
    settle();
    chk("rstdiv.busy", 32'(div_busy), 32'd0);
    chk("rstdiv.ready", 32'(bundle_ready), 32'd1);
    chk("rstdiv.count", stall_cycle_count, 32'd0);
    outs("rstdiv", 3'b000, 1'b0, 1'b0);
    exp_cnt = 0;

    // MEMORY/ALU/MEMORY with mem_ready low for 3 ISSUE cycles.
    // Expected issue sequence: 010, 000, 000, then 001, then 100 with done.
    mem_ready = 1'b0;
    offer(3'b111, MEM, ALU, MEM);
    tick(); bundle_valid = 1'b0;
    outs("mem.c1", 3'b010, 1'b0, 1'b1);
    tick(); outs("mem.c2", 3'b000, 1'b0, 1'b1);
    tick(); outs("mem.c3", 3'b000, 1'b0, 1'b1);
    tick(); mem_ready = 1'b1;
    outs("mem.c4", 3'b001, 1'b0, 1'b1);
    tick(); outs("mem.c5", 3'b100, 1'b1, 1'b0);
    exp_cnt += 4;
    chk("mem.count", stall_cycle_count, exp_cnt);
    tick();

    // Flush in the second ISSUE cycle of MUL/MUL/MUL.
    offer(3'b111, MUL, MUL, MUL);
    tick(); bundle_valid = 1'b0;
    outs("fl.c1", 3'b001, 1'b0, 1'b1);
    tick(); flush = 1'b1;
    outs("fl.c2", 3'b000, 1'b0, 1'b0);
    chk("fl.c2.ready", 32'(bundle_ready), 32'd0);
    tick(); flush = 1'b0;
    settle();
    chk("fl.after.ready", 32'(bundle_ready), 32'd1);
    outs("fl.after", 3'b000, 1'b0, 1'b0);
    exp_cnt += 1;
    chk("fl.count", stall_cycle_count, exp_cnt);
    // Pending was cleared, so the scheduler stays idle.
    tick();
    outs("fl.idle", 3'b000, 1'b0, 1'b0);

    // A flush in IDLE blocks acceptance of the offered bundle.
    flush = 1'b1; offer(3'b111, ALU, ALU, ALU);
    settle();
    chk("flidle.ready", 32'(bundle_ready), 32'd0);
    tick(); flush = 1'b0; bundle_valid = 1'b0;
    outs("flidle.next", 3'b000, 1'b0, 1'b0);

    // FPU/FPU/BRANCH: A and C issue, then B.
    offer(3'b111, FPU, FPU, BRA);
    tick(); bundle_valid = 1'b0;
    outs("fpu.c1", 3'b101, 1'b0, 1'b1);
    tick(); outs("fpu.c2", 3'b010, 1'b1, 1'b0);
    tick();

    // SYSTEM/BRANCH/SYSTEM with C disabled: A and B issue in one cycle.
    offer(3'b011, SYS, BRA, SYS);
    tick(); bundle_valid = 1'b0;
    outs("sys.c1", 3'b011, 1'b1, 1'b0);
    tick();

    // All-NOP bundle: done in the first ISSUE cycle, and nothing issues.
    offer(3'b111, NOP, NOP, NOP);
    tick(); bundle_valid = 1'b0;
    outs("nop.c1", 3'b000, 1'b1, 1'b0);
    tick();

    // All slots disabled: done at once.
    offer(3'b000, MUL, DIV, MEM);
    tick(); bundle_valid = 1'b0;
    outs("dis.c1", 3'b000, 1'b1, 1'b0);
    tick();
    exp_cnt += 1;
    settle();
    chk("end.count", stall_cycle_count, exp_cnt);
    chk("end.ready", 32'(bundle_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
